// File: rtl/fetch_buf.sv
// fetch_buf: instruction fetch unit feeding ID through a DEPTH-entry prefetch queue.
// Optional macro FETCH_BUF_BYPASS_EN: a response that reaches an empty queue is shown to ID in the same cycle.
module fetch_buf #(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              rom_ce_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [DATA_W-1:0] rom_data_i,
   input  logic              branch_flag_i,
   input  logic [ADDR_W-1:0] branch_target_address_i,
   input  logic              id_stall_i,
   output logic              id_valid_o,
   output logic [ADDR_W-1:0] id_pc_o,
   output logic [DATA_W-1:0] id_inst_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   typedef enum logic [1:0] {BOOT, RUN, REDIRECT} state_t;
   state_t state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, pend_pc_q, pend_pc_d;
   logic pend_q, pend_d;
   logic [PW-1:0] head_q, head_d, tail;
   logic [CW-1:0] count_q, count_d;
   logic [ADDR_W-1:0] mem_pc [DEPTH];
   logic [DATA_W-1:0] mem_inst [DEPTH];
   logic has_q, byp, pop, pop_q_entry, push;
   assign has_q = count_q != '0;
`ifdef FETCH_BUF_BYPASS_EN
   assign byp = pend_q && !branch_flag_i && !has_q;
`else
   assign byp = 1'b0;
`endif
   assign id_valid_o  = has_q || byp;
   assign id_pc_o     = has_q ? mem_pc[head_q] : byp ? pend_pc_q : '0;
   assign id_inst_o   = has_q ? mem_inst[head_q] : byp ? rom_data_i : '0;
   assign pop         = id_valid_o && !id_stall_i && !branch_flag_i;
   assign pop_q_entry = pop && has_q;
   assign push        = pend_q && !branch_flag_i && !(byp && pop);
   assign tail        = head_q + count_q[PW-1:0];
   assign rom_ce_o    = state_q != BOOT && !branch_flag_i && (count_q + CW'(pend_q)) < CW'(DEPTH);
   assign rom_addr_o  = pc_q;
   // next-state: a branch flushes everything and redirects, otherwise fetch and queue advance
   always_comb begin
      state_d   = branch_flag_i ? REDIRECT : RUN;
      pc_d      = branch_flag_i ? branch_target_address_i : rom_ce_o ? pc_q + ADDR_W'(4) : pc_q;
      pend_d    = rom_ce_o;
      pend_pc_d = rom_ce_o ? pc_q : pend_pc_q;
      head_d    = pop_q_entry ? head_q + PW'(1) : head_q;
      count_d   = branch_flag_i ? '0 : count_q + CW'(push) - CW'(pop_q_entry);
   end
   // control state with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= BOOT;
         pc_q      <= RESET_PC;
         pend_q    <= 1'b0;
         pend_pc_q <= '0;
         head_q    <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pend_q    <= pend_d;
         pend_pc_q <= pend_pc_d;
         head_q    <= head_d;
         count_q   <= count_d;
      end
   end
   // queue storage; contents are only meaningful below count_q so no reset is needed
   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[tail]   <= pend_pc_q;
         mem_inst[tail] <= rom_data_i;
      end
   end
endmodule

// File: doc/fetch_buf.md
FETCH_BUF -- requirements
Module: fetch_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, instruction address width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port rom_ce_o  output  1  fetch request to instruction ROM this cycle.
REQ-008 SHALL have port rom_addr_o  output  ADDR_W  fetch address, valid when rom_ce_o=1.
REQ-009 SHALL have port rom_data_i  input  DATA_W  ROM data, valid the cycle after a request.
REQ-010 SHALL have port branch_flag_i  input  1  redirect request from ID.
REQ-011 SHALL have port branch_target_address_i  input  ADDR_W  redirect target.
REQ-012 SHALL have port id_stall_i  input  1  ID cannot accept an instruction this cycle.
REQ-013 SHALL have port id_valid_o  output  1  id_pc_o/id_inst_o hold a valid instruction.
REQ-014 SHALL have port id_pc_o  output  ADDR_W  PC of the presented instruction.
REQ-015 SHALL have port id_inst_o  output  DATA_W  presented instruction word.

Function
REQ-016 SHALL implement FSM states BOOT, RUN, REDIRECT; BOOT entered on reset, left to RUN after one cycle.
REQ-017 SHALL assert rom_ce_o only in RUN or REDIRECT, and only when count + pending < DEPTH, where pending = request issued last cycle and not dropped.
REQ-018 SHALL drive rom_addr_o = fetch PC; fetch PC advances by 4 (modulo 2^ADDR_W, wrap allowed) on every issued request.
REQ-019 SHALL push {issued PC, rom_data_i} into the queue tail in the cycle after a request unless that response is marked dropped.
REQ-020 SHALL drive id_valid_o = (count != 0) and id_pc_o/id_inst_o from the head entry; id_* outputs hold stable while id_stall_i=1.
REQ-021 SHALL pop the head when id_valid_o=1, id_stall_i=0 and branch_flag_i=0.
REQ-022 SHALL permit push and pop in the same cycle, count unchanged, including when count = DEPTH-1 or DEPTH.
REQ-023 SHALL, when branch_flag_i=1 in any state: clear count to 0, set fetch PC to branch_target_address_i, mark any in-flight response dropped, deassert rom_ce_o that cycle, and enter REDIRECT.
REQ-024 SHALL, in REDIRECT, issue a fetch of the target PC and move to RUN; a further branch_flag_i in REDIRECT restarts REDIRECT with the new target.
REQ-025 SHALL never overflow: push with count=DEPTH and no pop cannot occur by construction of REQ-017.
REQ-026 SHALL ignore id_stall_i for redirect; branch takes priority over pop and push.

Reset
REQ-027 SHALL, while rst=0, force: state=BOOT, count=0, pending=0, fetch PC=RESET_PC, rom_ce_o=0, rom_addr_o=RESET_PC, id_valid_o=0, id_pc_o=0, id_inst_o=0.
REQ-028 SHALL, on reset assertion mid-operation, discard all queue contents and the in-flight response; first fetch after release is RESET_PC on the second rising edge.

Configuration
REQ-029 SHALL support macro FETCH_BUF_BYPASS_EN.
REQ-030 SHALL, with FETCH_BUF_BYPASS_EN defined, present a non-dropped response arriving while count=0 directly on id_* in the same cycle (id_valid_o=1) and not enqueue it if popped that cycle.
REQ-031 SHALL, without FETCH_BUF_BYPASS_EN, always enqueue responses first; minimum request-to-id_valid_o latency is 2 cycles.

Verification
REQ-032 SHALL cover reset release, DEPTH=4, id_stall_i=0: rom_addr_o = 0,4,8,12... on consecutive cycles; id_pc_o follows one instruction per cycle after initial latency (1 with bypass, 2 without).
REQ-033 SHALL cover id_stall_i=1 held 10 cycles: exactly 4 entries fill, rom_ce_o deasserts, id_pc_o=0 stable; on release, pops resume with PC 0,4,8,12,16 and no loss or duplicate.
REQ-034 SHALL cover branch_flag_i=1 with target 0x100 while queue holds 3 entries and a request in flight: next id_pc_o valid value is 0x100, stale PCs never appear, next rom_addr_o=0x100 in REDIRECT.
REQ-035 SHALL cover back-to-back branches to 0x200 then 0x300: only 0x300 instructions reach ID.
REQ-036 SHALL cover fetch PC 0xFFFFFFFC with ADDR_W=32: next fetch address 0x00000000.
REQ-037 SHALL cover rst=0 asserted with queue full: all outputs reach REQ-027 values asynchronously; restart fetches RESET_PC.
